// File: rtl/l1_data_cache_hitrate_monitor.sv
// L1 data cache hit-rate monitor: masks counter warm-up, debounced low/high thresholds, level IRQ with ack, low-watermark.
// Latency: all outputs registered, one edge per FSM transition; no backpressure, every cycle's count is consumed.
module l1_data_cache_hitrate_monitor #(
  parameter logic [6:0] P_LOW_TH   = 7'd60,
  parameter logic [6:0] P_HIGH_TH  = 7'd80,
  parameter logic [3:0] P_DEBOUNCE = 4'd8
) (
  input  logic       iCLOCK,
  input  logic       iRESET,
  input  logic       iCACHE_VALID,
  input  logic [6:0] iINFO_COUNT,
  input  logic       iCONFIG_ENABLE,
  input  logic       iIRQ_ACK,
  output logic       oWINDOW_VALID,
  output logic [2:0] oSTATE,
  output logic       oLOW_HITRATE,
  output logic       oIRQ_REQ,
  output logic [6:0] oMIN_COUNT
);

  typedef enum logic [2:0] {
    ST_WARMUP  = 3'd0,
    ST_NORMAL  = 3'd1,
    ST_FALLING = 3'd2,
    ST_LOW     = 3'd3,
    ST_RISING  = 3'd4
  } state_e;

  localparam logic [6:0] WINDOW_LEN = 7'd100;
  localparam logic [6:0] MIN_RESET  = 7'd127;

  logic [6:0] warm_cnt_q, warm_cnt_d;
  logic [1:0] lat_cnt_q, lat_cnt_d;
  logic       win_q, win_d;
  state_e     state_q, state_d;
  logic [3:0] deb_q, deb_d;
  logic       low_q, low_d;
  logic       irq_q, irq_d;
  logic [6:0] min_q, min_d;
  logic       enter_low;
  logic       is_low;
  logic       is_high;

  assign is_low  = iINFO_COUNT < P_LOW_TH;
  assign is_high = iINFO_COUNT > P_HIGH_TH;

  // The upstream counter's output lags its 100th access by three pipeline stages.
  always_comb begin
    warm_cnt_d = warm_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    win_d      = win_q;
    if (iCACHE_VALID && (warm_cnt_q < WINDOW_LEN)) begin
      warm_cnt_d = warm_cnt_q + 7'd1;
    end
    if ((warm_cnt_q == WINDOW_LEN) && !win_q) begin
      if (lat_cnt_q == 2'd2) begin
        win_d = 1'b1;
      end else begin
        lat_cnt_d = lat_cnt_q + 2'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    deb_d     = deb_q;
    enter_low = 1'b0;
    if (!iCONFIG_ENABLE) begin
      state_d = ST_WARMUP;
      deb_d   = 4'd0;
    end else begin
      case (state_q)
        ST_WARMUP: begin
          if (win_q) begin
            state_d = ST_NORMAL;
          end
        end
        ST_NORMAL: begin
          if (is_low) begin
            state_d = ST_FALLING;
            deb_d   = 4'd1;
          end
        end
        ST_FALLING: begin
          if (!is_low) begin
            state_d = ST_NORMAL;
            deb_d   = 4'd0;
          end else if (deb_q == (P_DEBOUNCE - 4'd1)) begin
            state_d   = ST_LOW;
            deb_d     = 4'd0;
            enter_low = 1'b1;
          end else begin
            deb_d = deb_q + 4'd1;
          end
        end
        ST_LOW: begin
          if (is_high) begin
            state_d = ST_RISING;
            deb_d   = 4'd1;
          end
        end
        ST_RISING: begin
          if (!is_high) begin
            state_d = ST_LOW;
            deb_d   = 4'd0;
          end else if (deb_q == (P_DEBOUNCE - 4'd1)) begin
            state_d = ST_NORMAL;
            deb_d   = 4'd0;
          end else begin
            deb_d = deb_q + 4'd1;
          end
        end
        default: begin
          state_d = ST_WARMUP;
          deb_d   = 4'd0;
        end
      endcase
    end
  end

  // A new LOW entry must not be lost to an ack arriving in the same cycle.
  always_comb begin
    low_d = (state_d == ST_LOW) || (state_d == ST_RISING);
    irq_d = irq_q;
    if (enter_low) begin
      irq_d = 1'b1;
    end else if (iIRQ_ACK) begin
      irq_d = 1'b0;
    end
    min_d = min_q;
    if (iIRQ_ACK) begin
      min_d = MIN_RESET;
    end else if (win_q && iCONFIG_ENABLE && (iINFO_COUNT < min_q)) begin
      min_d = iINFO_COUNT;
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      warm_cnt_q <= 7'd0;
      lat_cnt_q  <= 2'd0;
      win_q      <= 1'b0;
      state_q    <= ST_WARMUP;
      deb_q      <= 4'd0;
      low_q      <= 1'b0;
      irq_q      <= 1'b0;
      min_q      <= MIN_RESET;
    end else begin
      warm_cnt_q <= warm_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      win_q      <= win_d;
      state_q    <= state_d;
      deb_q      <= deb_d;
      low_q      <= low_d;
      irq_q      <= irq_d;
      min_q      <= min_d;
    end
  end

  assign oWINDOW_VALID = win_q;
  assign oSTATE        = state_q;
  assign oLOW_HITRATE  = low_q;
  assign oIRQ_REQ      = irq_q;
  assign oMIN_COUNT    = min_q;

endmodule
